// File: rtl/mux_4_1_arbiter.sv
// mux_4_1_arbiter: four-requester round-robin arbiter with a bounded hold time
// and a registered 4:1 data mux steered by the current owner.
module mux_4_1_arbiter #(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         req,
    input  logic [4*WIDTH-1:0] I,
    output logic [3:0]         gnt,
    output logic [1:0]         s,
    output logic               valid,
    output logic [WIDTH-1:0]   Y
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [3:0] HOLD_LIMIT = 4'(MAX_HOLD);

    state_t     state_reg;
    logic [1:0] owner_reg;
    logic [1:0] last_reg;
    logic [3:0] cnt_reg;

    // Split the flat data bus into addressable lanes.
    logic [WIDTH-1:0] lanes [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lanes[gi] = I[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // One-hot mask of the current owner, used to exclude it from re-arbitration.
    logic [3:0] owner_mask;
    always_comb begin
        owner_mask = 4'b0001 << owner_reg;
    end

    // Search base and candidate set: from IDLE search after last over all
    // requests; from GRANT search after the owner with the owner excluded.
    logic [1:0] search_base;
    logic [3:0] req_masked;
    always_comb begin
        search_base = last_reg;
        req_masked  = req;
        if (state_reg == GRANT) begin
            search_base = owner_reg;
            req_masked  = req & ~owner_mask;
        end
    end

    // Rotating priority search: first set bit at base+1, base+2, ... modulo 4.
    logic       pick_found;
    logic [1:0] pick_idx;
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            if (!pick_found && req_masked[search_base + 2'(k)]) begin
                pick_found = 1'b1;
                pick_idx   = search_base + 2'(k);
            end
        end
    end

    // Release when the owner stops requesting, or when its hold budget is
    // spent and someone else is waiting.
    logic hold_spent;
    logic others_waiting;
    logic release_now;
    always_comb begin
        hold_spent     = (cnt_reg == HOLD_LIMIT);
        others_waiting = |(req & ~owner_mask);
        release_now    = !req[owner_reg] || (hold_spent && others_waiting);
    end

    // Arbiter FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            owner_reg <= 2'd0;
            last_reg  <= 2'd3;
            cnt_reg   <= 4'd0;
            gnt       <= 4'b0000;
            s         <= 2'd0;
            valid     <= 1'b0;
            Y         <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (pick_found) begin
                        state_reg <= GRANT;
                        owner_reg <= pick_idx;
                        cnt_reg   <= 4'd1;
                        gnt       <= 4'b0001 << pick_idx;
                        s         <= pick_idx;
                        valid     <= 1'b1;
                        Y         <= lanes[pick_idx];
                    end else begin
                        gnt   <= 4'b0000;
                        valid <= 1'b0;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        last_reg <= owner_reg;
                        if (pick_found) begin
                            // Hand over directly, no idle gap.
                            owner_reg <= pick_idx;
                            cnt_reg   <= 4'd1;
                            gnt       <= 4'b0001 << pick_idx;
                            s         <= pick_idx;
                            valid     <= 1'b1;
                            Y         <= lanes[pick_idx];
                        end else begin
                            state_reg <= IDLE;
                            gnt       <= 4'b0000;
                            valid     <= 1'b0;
                        end
                    end else begin
                        if (cnt_reg < HOLD_LIMIT) begin
                            cnt_reg <= cnt_reg + 4'd1;
                        end
                        Y <= lanes[owner_reg];
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    gnt       <= 4'b0000;
                    valid     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_4_1_arbiter.sv
// Bench for mux_4_1_arbiter: directed scenarios with literal expectations
// plus a randomized run, all checked every cycle against a behavioural model.
module tb_mux_4_1_arbiter;

    localparam int W  = 8;
    localparam int MH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [3:0]       req;
    logic [4*W-1:0]   I;
    logic [3:0]       gnt;
    logic [1:0]       s;
    logic             valid;
    logic [W-1:0]     Y;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    mux_4_1_arbiter #(.WIDTH(W), .MAX_HOLD(MH)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .I     (I),
        .gnt   (gnt),
        .s     (s),
        .valid (valid),
        .Y     (Y)
    );

    // Behavioural model state.
    bit         m_act;
    int         m_owner;
    int         m_last;
    int         m_cnt;
    logic [1:0] m_s;
    logic [W-1:0] m_y;

    function automatic logic [W-1:0] lane_of(logic [4*W-1:0] bus, int i);
        return bus[i*W +: W];
    endfunction

    // First requester after 'after' in circular order, skipping 'excl'; -1 if none.
    function automatic int pick(logic [3:0] r, int after, int excl);
        for (int k = 1; k <= 4; k++) begin
            int idx;
            idx = (after + k) % 4;
            if (r[idx] && idx != excl) return idx;
        end
        return -1;
    endfunction

    task automatic model_step();
        int p;
        bit others;
        if (rst) begin
            m_act = 0; m_owner = 0; m_last = 3; m_cnt = 0; m_s = 2'd0; m_y = '0;
        end else if (!m_act) begin
            p = pick(req, m_last, -1);
            if (p >= 0) begin
                m_act = 1; m_owner = p; m_cnt = 1; m_s = 2'(p); m_y = lane_of(I, p);
            end
        end else begin
            others = 0;
            for (int i = 0; i < 4; i++) if (i != m_owner && req[i]) others = 1;
            if (!req[m_owner] || (m_cnt == MH && others)) begin
                m_last = m_owner;
                p = pick(req, m_owner, m_owner);
                if (p >= 0) begin
                    m_owner = p; m_cnt = 1; m_s = 2'(p); m_y = lane_of(I, p);
                end else begin
                    m_act = 0;
                end
            end else begin
                if (m_cnt < MH) m_cnt = m_cnt + 1;
                m_y = lane_of(I, m_owner);
            end
        end
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Apply one set of inputs across one rising edge, advance the model,
    // then compare every output at the falling edge.
    task automatic cycle(input logic r, input logic [3:0] q, input logic [4*W-1:0] d);
        logic [3:0] m_gnt;
        rst = r; req = q; I = d;
        @(posedge clk);
        model_step();
        @(negedge clk);
        cyc++;
        m_gnt = m_act ? (4'b0001 << m_owner) : 4'b0000;
        $display("[TB] cyc %0d rst=%b req=%b gnt=%b s=%0d valid=%b Y=%h", cyc, r, q, gnt, s, valid, Y);
        check("model_gnt",   32'(gnt),   32'(m_gnt));
        check("model_s",     32'(s),     32'(m_s));
        check("model_valid", 32'(valid), 32'(m_act));
        check("model_Y",     32'(Y),     32'(m_y));
    endtask

    function automatic logic [4*W-1:0] lanes4(logic [W-1:0] a0, logic [W-1:0] a1,
                                              logic [W-1:0] a2, logic [W-1:0] a3);
        return {a3, a2, a1, a0};
    endfunction

    int exp_rot [17] = '{0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0};

    initial begin
        logic [3:0]     rq;
        logic [4*W-1:0] data;
        rst = 1'b1; req = 4'b0; I = '0;

        // Scenario 1: reset state, then single request on lane 0.
        cycle(1'b1, 4'b0000, '0);
        check("reset_gnt",   32'(gnt),   32'h0);
        check("reset_valid", 32'(valid), 32'h0);
        check("reset_Y",     32'(Y),     32'h0);
        cycle(1'b0, 4'b0001, lanes4(8'hA5, 8'h01, 8'h02, 8'h03));
        check("s1_gnt",   32'(gnt),   32'h1);
        check("s1_s",     32'(s),     32'h0);
        check("s1_valid", 32'(valid), 32'h1);
        check("s1_Y",     32'(Y),     32'hA5);

        // Scenario 2: all requesting, rotation with 4-cycle holds, no gaps.
        cycle(1'b1, 4'b0000, '0);
        for (int c = 0; c < 17; c++) begin
            cycle(1'b0, 4'b1111, lanes4(8'h10, 8'h20, 8'h30, 8'h40));
            check("s2_owner", 32'(s),     32'(exp_rot[c]));
            check("s2_valid", 32'(valid), 32'h1);
        end

        // Scenario 3: owner 1 drops while 2 raises at the same edge.
        cycle(1'b1, 4'b0000, '0);
        cycle(1'b0, 4'b0010, lanes4(8'h00, 8'h11, 8'h22, 8'h33));
        cycle(1'b0, 4'b0010, lanes4(8'h00, 8'h11, 8'h22, 8'h33));
        check("s3_pre_gnt", 32'(gnt), 32'h2);
        cycle(1'b0, 4'b0100, lanes4(8'h00, 8'h11, 8'h22, 8'h33));
        check("s3_gnt",   32'(gnt),   32'h4);
        check("s3_s",     32'(s),     32'h2);
        check("s3_valid", 32'(valid), 32'h1);
        check("s3_Y",     32'(Y),     32'h22);

        // Scenario 4: lone requester 3 keeps the grant past MAX_HOLD.
        cycle(1'b1, 4'b0000, '0);
        for (int c = 0; c < 10; c++) begin
            cycle(1'b0, 4'b1000, lanes4(8'h00, 8'h00, 8'h00, 8'(c)));
            check("s4_gnt", 32'(gnt), 32'h8);
        end
        cycle(1'b0, 4'b0000, '0);
        check("s4_idle_valid", 32'(valid), 32'h0);
        check("s4_idle_gnt",   32'(gnt),   32'h0);
        check("s4_hold_s",     32'(s),     32'h3);

        // Scenario 5: reset mid-grant, then requester 1 wins first.
        cycle(1'b1, 4'b0000, '0);
        cycle(1'b0, 4'b0110, lanes4(8'h00, 8'h5A, 8'h6B, 8'h00));
        cycle(1'b0, 4'b0110, lanes4(8'h00, 8'h5A, 8'h6B, 8'h00));
        cycle(1'b1, 4'b0110, lanes4(8'h00, 8'h5A, 8'h6B, 8'h00));
        check("s5_rst_gnt",   32'(gnt),   32'h0);
        check("s5_rst_valid", 32'(valid), 32'h0);
        check("s5_rst_Y",     32'(Y),     32'h0);
        cycle(1'b0, 4'b0110, lanes4(8'h00, 8'h5A, 8'h6B, 8'h00));
        check("s5_gnt", 32'(gnt), 32'h2);

        // Scenario 6: data on the granted lane changes mid-grant.
        cycle(1'b1, 4'b0000, '0);
        cycle(1'b0, 4'b0100, lanes4(8'h00, 8'h00, 8'h11, 8'h00));
        check("s6_Y_first", 32'(Y), 32'h11);
        cycle(1'b0, 4'b0100, lanes4(8'h00, 8'h00, 8'h22, 8'h00));
        check("s6_Y_change", 32'(Y), 32'h22);

        // Randomized run: sticky requests so holds and saturation get exercised.
        rq = 4'b0000;
        data = '0;
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 3) == 0) rq = 4'($urandom);
            if ($urandom_range(0, 1) == 0) data = {$urandom};
            cycle(($urandom_range(0, 79) == 0), rq, data);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mux_4_1_arbiter.md
MUX_4_1_ARBITER -- requirements
Module: mux_4_1_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, setting the bit width of each data lane.
REQ-002 SHALL have parameter MAX_HOLD, default 4, setting the maximum number of grant cycles while another requester waits (legal range 1..15).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port req, input, 4 bits: request from requester i on bit i.
REQ-006 SHALL have port I, input, 4*WIDTH bits: data lanes, with lane i at I[i*WIDTH +: WIDTH].
REQ-007 SHALL have port gnt, output, 4 bits: one-hot grant, all zeros when idle.
REQ-008 SHALL have port s, output, 2 bits: encoded index of the current owner, the mux select.
REQ-009 SHALL have port valid, output, 1 bit: high while a grant is active.
REQ-010 SHALL have port Y, output, WIDTH bits: registered mux output.

Function
REQ-011 SHALL implement a two-state FSM with states IDLE and GRANT; all outputs registered.
REQ-012 SHALL keep internal state: owner (2 bits), last pointer (2 bits), and hold counter (4 bits).
REQ-013 IDLE: at an edge with req != 0, SHALL enter GRANT with owner = first set req bit searching last+1, last+2, ... modulo 4.
REQ-014 IDLE with req == 0 SHALL remain in IDLE with gnt=0, valid=0, and s and Y holding their last values.
REQ-015 Grant latency SHALL be one cycle: req sampled at edge k, so gnt, s and valid are valid after edge k.
REQ-016 GRANT: gnt SHALL equal 1<<owner, s SHALL equal owner, and valid SHALL be 1.
REQ-017 At each edge ending in GRANT, Y SHALL load lane[new owner] of I sampled at that edge, giving one-cycle data latency.
REQ-018 Hold counter SHALL reset to 1 on each new grant and increment each held cycle, saturating at MAX_HOLD.
REQ-019 Release SHALL occur at an edge in GRANT when req[owner] == 0, or when counter == MAX_HOLD and any other req bit is set.
REQ-020 On release, last SHALL be set to owner, and the next owner SHALL be arbitrated per REQ-013 over req with the current owner's bit excluded.
REQ-021 On release with a candidate, SHALL switch directly to the new owner with no idle cycle between grants.
REQ-022 On release with no candidate, SHALL enter IDLE and clear gnt and valid.
REQ-023 With counter == MAX_HOLD and no other requester, SHALL retain the grant and keep the counter saturated.
REQ-024 Owner deasserting req and another requester asserting at the same edge SHALL be handled as REQ-021.
REQ-025 A requester dropping req before being granted SHALL not be granted, since only the req sampled at arbitration counts.
REQ-026 gnt SHALL be one-hot or zero in every cycle.

Reset
REQ-027 rst high at an edge SHALL force state=IDLE, gnt=0, s=00, valid=0, Y=0, owner=0, last=3, and counter=0.
REQ-028 rst SHALL take priority over all requests, including mid-grant, and the first grant after reset SHALL favour requester 0.

Verification
REQ-029 Scenario 1, reset then req=0001 and lane0=8'hA5:
- after the next edge, gnt=0001, s=00, valid=1, Y=A5.
REQ-030 Scenario 2, req=1111 held continuously with MAX_HOLD=4:
- grants rotate 0,1,2,3,0, with each owner holding exactly 4 cycles and no gap cycles.
REQ-031 Scenario 3, owner 1 holds, then req changes from 0010 to 0100 at one edge:
- after that edge, gnt=0100, s=10, valid stays 1 with no gap.
REQ-032 Scenario 4, only req=1000 held for 10 cycles:
- gnt stays 1000 throughout.
- once req drops to 0000, after the next edge valid=0 and gnt=0.
REQ-033 Scenario 5, rst asserted for one edge mid-grant with req=0110:
- at that edge, outputs take reset values.
- after the following edge, gnt=0010, because last=3 gives priority order 0,1,2,3.
REQ-034 Scenario 6, during a grant to lane 2, I lane2 changes 8'h11 -> 8'h22:
- Y shows 22 one cycle after the change.
